// File: rtl/i2c_pkg.sv
// Shared types and constants for the WM8731-style I2C write target.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_HI,
        S_HI_ACK,
        S_LO,
        S_LO_ACK,
        S_DONE,
        S_IGNORE
    } i2c_tgt_state_e;

    localparam logic [6:0] WM_DEV_ADDR = 7'h1A;
    localparam int         WM_WORD_W   = 16;

    localparam int WM_REG_LLINE  = 0;
    localparam int WM_REG_RLINE  = 1;
    localparam int WM_REG_LHP    = 2;
    localparam int WM_REG_RHP    = 3;
    localparam int WM_REG_APATH  = 4;
    localparam int WM_REG_DPATH  = 5;
    localparam int WM_REG_PWR    = 6;
    localparam int WM_REG_IFACE  = 7;
    localparam int WM_REG_SRATE  = 8;
    localparam int WM_REG_ACTIVE = 9;
    localparam int WM_REG_RESET  = 15;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with edge, START and STOP detection.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchroniser.
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [1:0] scl_ff, sda_ff;
    logic       scl_c, sda_c, scl_q, sda_q;

    // Reset to 1 so an idle bus does not look like an edge when reset is released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
        end else begin
            scl_ff <= {scl_ff[0], i_scl};
            sda_ff <= {sda_ff[0], i_sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0] scl_h, sda_h;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_h <= 3'b111;
            sda_h <= 3'b111;
        end else begin
            scl_h <= {scl_h[1:0], scl_ff[1]};
            sda_h <= {sda_h[1:0], sda_ff[1]};
        end
    end

    assign scl_c = (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2]) | (scl_h[1] & scl_h[2]);
    assign sda_c = (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2]) | (sda_h[1] & sda_h[2]);
`else
    assign scl_c = scl_ff[1];
    assign sda_c = sda_ff[1];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_c;
            sda_q <= sda_c;
        end
    end

    assign sda       = sda_c;
    assign scl_rise  = scl_c & ~scl_q;
    assign scl_fall  = ~scl_c & scl_q;
    assign start_det = scl_c & scl_q & sda_q & ~sda_c;
    assign stop_det  = scl_c & scl_q & ~sda_q & sda_c;

endmodule

// File: rtl/i2c_codec_target.sv
// WM8731 control-port model: I2C write target feeding a 9-bit shadow register file.
// Optional I2C_GLITCH_FILTER_EN enables majority filtering inside i2c_line_sync.
module i2c_codec_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = WM_DEV_ADDR,
    parameter int         NUM_REGS = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    inout  wire        io_sdat,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    output logic       o_reset_pulse,
    output logic       o_bad_reg,
    output logic       o_active,
    output logic       o_busy
);
    i2c_tgt_state_e state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_q, hi_q, next_byte;
    logic [6:0]     word_addr;
    logic [8:0]     word_data;
    logic           ack_hold, sda_oe;
    logic           sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [8:0]     regs [NUM_REGS];

    i2c_line_sync u_sync (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_scl     (i_scl),
        .i_sda     (io_sdat),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign io_sdat   = sda_oe ? 1'b0 : 1'bz;
    assign next_byte = {shift_q[6:0], sda_s};
    assign word_addr = hi_q[7:1];
    assign word_data = {hi_q[0], shift_q};
    assign o_active  = regs[WM_REG_ACTIVE][0];

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (i_rd_addr == 4'(i)) o_rd_data = regs[i];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            shift_q       <= '0;
            hi_q          <= '0;
            ack_hold      <= 1'b0;
            sda_oe        <= 1'b0;
            o_busy        <= 1'b0;
            o_wr_valid    <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_reset_pulse <= 1'b0;
            o_bad_reg     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            o_wr_valid    <= 1'b0;
            o_reset_pulse <= 1'b0;
            o_bad_reg     <= 1'b0;
            if (start_det) begin
                state    <= S_ADDR;
                bit_cnt  <= '0;
                ack_hold <= 1'b0;
                sda_oe   <= 1'b0;
                o_busy   <= 1'b1;
            end else if (stop_det) begin
                state    <= S_IDLE;
                ack_hold <= 1'b0;
                sda_oe   <= 1'b0;
                o_busy   <= 1'b0;
            end else begin
                unique case (state)
                    S_ADDR, S_HI, S_LO: begin
                        if (scl_rise) begin
                            shift_q <= next_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == S_ADDR)
                                    state <= (next_byte[7:1] == DEV_ADDR && !next_byte[0])
                                             ? S_ADDR_ACK : S_IGNORE;
                                else if (state == S_HI) begin
                                    hi_q  <= next_byte;
                                    state <= S_HI_ACK;
                                end else
                                    state <= S_LO_ACK;
                            end
                        end
                    end
                    // First SCL fall after bit 8 drives ACK, the next one releases it.
                    S_ADDR_ACK, S_HI_ACK, S_LO_ACK: begin
                        if (scl_fall) begin
                            sda_oe   <= !ack_hold;
                            ack_hold <= !ack_hold;
                            if (ack_hold) begin
                                if (state == S_ADDR_ACK)
                                    state <= S_HI;
                                else if (state == S_HI_ACK)
                                    state <= S_LO;
                                else begin
                                    state <= S_DONE;
                                    if (word_addr == 7'(WM_REG_RESET)) begin
                                        for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                                        o_reset_pulse <= 1'b1;
                                        o_wr_valid    <= 1'b1;
                                        o_wr_addr     <= word_addr;
                                        o_wr_data     <= word_data;
                                    end else if (word_addr < 7'(NUM_REGS)) begin
                                        for (int i = 0; i < NUM_REGS; i++)
                                            if (word_addr == 7'(i)) regs[i] <= word_data;
                                        o_wr_valid <= 1'b1;
                                        o_wr_addr  <= word_addr;
                                        o_wr_data  <= word_data;
                                    end else
                                        o_bad_reg <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: bit-banged I2C master, spec-level register model and event scoreboard.
module tb_i2c_codec_target;

    localparam int Q = 8;

    typedef struct {
        int         kind;
        logic [6:0] a;
        logic [8:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [8:0] rd_data;
    logic       wr_valid, reset_pulse, bad_reg, active, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    wire        sda;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_codec_target dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_scl         (m_scl),
        .io_sdat       (sda),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_wr_valid    (wr_valid),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_reset_pulse (reset_pulse),
        .o_bad_reg     (bad_reg),
        .o_active      (active),
        .o_busy        (busy)
    );

    int         tests = 0;
    int         fails = 0;
    logic [8:0] mregs [16];
    logic [6:0] last_a = '0;
    logic [8:0] last_d = '0;
    ev_t        sb [$];
    ev_t        mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every commit-type pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && (wr_valid || bad_reg || reset_pulse)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got valid=%0b reset=%0b bad=%0b expected none",
                         wr_valid, reset_pulse, bad_reg);
            end else begin
                mon_e = sb.pop_front();
                chk("ev_wr_valid", wr_valid, mon_e.kind != 1);
                chk("ev_reset_pulse", reset_pulse, mon_e.kind == 2);
                chk("ev_bad_reg", bad_reg, mon_e.kind == 1);
                if (mon_e.kind != 1) begin
                    chk("ev_wr_addr", wr_addr, mon_e.a);
                    chk("ev_wr_data", wr_data, mon_e.d);
                end
            end
        end
    end

    task automatic wcyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        m_sda_low = 1'b0; m_scl = 1'b1; wcyc(Q);
        m_sda_low = 1'b1; wcyc(Q);
        m_scl = 1'b0; wcyc(Q);
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1; wcyc(Q);
        m_scl = 1'b1; wcyc(Q);
        m_sda_low = 1'b0; wcyc(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = !b[i]; wcyc(Q);
            m_scl = 1'b1; wcyc(2 * Q);
            m_scl = 1'b0; wcyc(Q);
        end
    endtask

    task automatic ack_bit(output logic acked);
        m_sda_low = 1'b0; wcyc(Q);
        m_scl = 1'b1; wcyc(Q);
        acked = (sda === 1'b0);
        wcyc(Q);
        m_scl = 1'b0; wcyc(Q);
    endtask

    task automatic model_word(input logic [15:0] w);
        ev_t e;
        e.a = w[15:9];
        e.d = w[8:0];
        if (e.a < 7'd10) begin
            mregs[e.a[3:0]] = e.d;
            e.kind = 0;
            last_a = e.a; last_d = e.d;
        end else if (e.a == 7'd15) begin
            for (int i = 0; i < 16; i++) mregs[i] = '0;
            e.kind = 2;
            last_a = e.a; last_d = e.d;
        end else
            e.kind = 1;
        sb.push_back(e);
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            chk($sformatf("%s_rd%0d", tag, i), rd_data, mregs[i]);
        end
        chk({tag, "_active"}, active, mregs[9][0]);
        chk({tag, "_wr_addr"}, wr_addr, last_a);
        chk({tag, "_wr_data"}, wr_data, last_d);
        chk({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    task automatic xfer(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] bytes [4];
        logic       acked;
        logic       addr_ok;
        bytes   = '{b0, b1, b2, b3};
        addr_ok = (b0 == 8'h34);
        if (addr_ok && n >= 3) model_word({b1, b2});
        m_start();
        for (int i = 0; i < n; i++) begin
            send_bits(bytes[i]);
            ack_bit(acked);
            chk($sformatf("%s_ack%0d", tag, i), acked, addr_ok && i < 3);
        end
        chk({tag, "_busy_in"}, busy, 1);
        m_stop();
        wcyc(10);
        chk({tag, "_busy_after"}, busy, 0);
        check_state(tag);
    endtask

    task automatic reset_in_hi_ack();
        logic acked;
        m_start();
        send_bits(8'h34);
        ack_bit(acked);
        chk("rst_addr_ack", acked, 1);
        send_bits(8'h12);
        m_sda_low = 1'b0; wcyc(Q);
        m_scl = 1'b1; wcyc(Q);
        chk("rst_ack_driven", sda, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_sda_released", sda, 1);
        chk("rst_busy_clear", busy, 0);
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        last_a = '0; last_d = '0;
        wcyc(4);
        rst_n = 1'b1;
        wcyc(4);
        m_scl = 1'b0; wcyc(Q);
        m_stop();
        wcyc(10);
        chk("rst_busy_after", busy, 0);
        check_state("rst");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        wcyc(5);
        chk("reset_sda", sda, 1);
        chk("reset_busy", busy, 0);
        chk("reset_valid", wr_valid, 0);
        chk("reset_bad", bad_reg, 0);
        chk("reset_rpulse", reset_pulse, 0);
        rst_n = 1'b1;
        wcyc(5);
        check_state("reset");

        xfer("r9_active", 3, 8'h34, 8'h12, 8'h01, 8'h00);
        chk("r9_active_hi", active, 1);
        xfer("r7", 3, 8'h34, 8'h0E, 8'h42, 8'h00);
        xfer("nack_addr", 1, 8'h36, 8'h00, 8'h00, 8'h00);
        xfer("rd_dir", 3, 8'h35, 8'h12, 8'h01, 8'h00);
        xfer("r9_again", 3, 8'h34, 8'h12, 8'h01, 8'h00);
        xfer("r15_reset", 3, 8'h34, 8'h1E, 8'h00, 8'h00);
        chk("r15_active_lo", active, 0);
        xfer("partial", 2, 8'h34, 8'h12, 8'h00, 8'h00);
        xfer("r8", 3, 8'h34, 8'h10, 8'h23, 8'h00);
        xfer("bad_r10", 3, 8'h34, 8'h14, 8'h05, 8'h00);
        xfer("extra_byte", 4, 8'h34, 8'h0B, 8'hFF, 8'h55);
        reset_in_hi_ack();
        xfer("post_rst", 3, 8'h34, 8'h03, 8'h7A, 8'h00);

        for (int t = 0; t < 24; t++) begin
            logic [7:0] b0;
            logic [6:0] ra;
            logic [8:0] d;
            int         n;
            int         sel;
            b0 = 8'h34;
            if ($urandom_range(0, 9) == 0) begin
                b0 = 8'($urandom_range(0, 255));
                if (b0 == 8'h34) b0 = 8'h35;
            end
            sel = $urandom_range(0, 9);
            if (sel < 7)       ra = 7'($urandom_range(0, 9));
            else if (sel == 7) ra = 7'd15;
            else               ra = 7'($urandom_range(10, 127));
            d = 9'($urandom_range(0, 511));
            sel = $urandom_range(0, 9);
            n = (sel < 7) ? 3 : (sel == 7) ? 1 : (sel == 8) ? 2 : 4;
            xfer($sformatf("rnd%0d", t), n, b0, {ra, d[8]}, d[7:0], 8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
